// File: rtl/fpu_postproc_sched.sv
// Scheduler for the shared FP post-processing unit: arbitrates between the
// pipelined M-stage op and a one-entry divsqrt result buffer, and keeps the
// sticky fflags register.

package fpu_postproc_pkg;
  typedef struct packed {
    int unsigned NF;  // exception flag count {NV,DZ,OF,UF,NX}
  } cvw_t;
  localparam cvw_t CVW_DEFAULT = '{NF: 5};
endpackage

module fpu_postproc_sched #(
  parameter fpu_postproc_pkg::cvw_t P = fpu_postproc_pkg::CVW_DEFAULT,
  parameter int MAXWAIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PipeValidM,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            DivDone,
  input  logic            DivFlush,
  input  logic [P.NF-1:0] PostProcFlg,
  input  logic            CSRFlagWe,
  input  logic [P.NF-1:0] CSRFlagWd,
  output logic            DivReady,
  output logic            PostProcSel,
  output logic            PipeGrant,
  output logic            DivGrant,
  output logic            SchedStallM,
  output logic            ResValid,
  output logic [P.NF-1:0] FFlags
);

  localparam int CW = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAXWAIT);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} divState_t;

  divState_t       state, stateNext;
  logic [CW-1:0]   WaitCnt, waitCntNext;
  logic [P.NF-1:0] fflagsNext;
  logic            PipeReq, DivPending;

  // Arbitration: the pipe normally wins, but a divsqrt result that has lost
  // MAXWAIT times in a row is forced through and the pipe op stalls.
  always_comb begin
    PipeReq     = PipeValidM & ~StallM & ~FlushM;
    DivPending  = (state == HELD);
    DivReady    = ~DivPending;
    DivGrant    = DivPending & ~DivFlush & (~PipeReq | (WaitCnt == MaxCnt));
    PipeGrant   = PipeReq & ~DivGrant;
    SchedStallM = PipeReq & DivGrant;
    PostProcSel = DivGrant;
    ResValid    = PipeGrant | DivGrant;
  end

  // Buffer next state and starvation counter; flush beats a same-cycle done,
  // and a done while HELD is ignored so the held result is never replaced.
  always_comb begin
    stateNext   = state;
    waitCntNext = WaitCnt;
    if (DivFlush) begin
      stateNext   = EMPTY;
      waitCntNext = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (DivDone) begin
            stateNext   = HELD;
            waitCntNext = '0;
          end
        end
        HELD: begin
          if (DivGrant) begin
            stateNext   = EMPTY;
            waitCntNext = '0;
          end else if (WaitCnt != MaxCnt) begin
            waitCntNext = WaitCnt + 1'b1;
          end
        end
        default: begin
          stateNext   = EMPTY;
          waitCntNext = '0;
        end
      endcase
    end
  end

  // Sticky flags: a CSR write replaces the register, but the granted op is
  // younger than the CSR write, so its flags are merged on top.
  always_comb begin
    fflagsNext = FFlags;
    if (CSRFlagWe)     fflagsNext = CSRFlagWd | (ResValid ? PostProcFlg : '0);
    else if (ResValid) fflagsNext = FFlags | PostProcFlg;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      WaitCnt <= '0;
      FFlags  <= '0;
    end else begin
      state   <= stateNext;
      WaitCnt <= waitCntNext;
      FFlags  <= fflagsNext;
    end
  end

endmodule

// File: tb/tb_fpu_postproc_sched.sv
module tb_fpu_postproc_sched;
  localparam int MAXWAIT = 3;

  logic       clk = 1'b0;
  logic       reset, PipeValidM, StallM, FlushM, DivDone, DivFlush, CSRFlagWe;
  logic [4:0] PostProcFlg, CSRFlagWd;
  logic       DivReady, PostProcSel, PipeGrant, DivGrant, SchedStallM, ResValid;
  logic [4:0] FFlags;

  int checks = 0, errors = 0;

  // Reference model state: is a div result waiting, how many times it has
  // lost in a row, and the sticky flags.
  bit         mPend;
  int         mLoss;
  logic [4:0] mFlags;
  bit         obsDivG;

  fpu_postproc_sched #(.MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .reset(reset), .PipeValidM(PipeValidM), .StallM(StallM),
    .FlushM(FlushM), .DivDone(DivDone), .DivFlush(DivFlush),
    .PostProcFlg(PostProcFlg), .CSRFlagWe(CSRFlagWe), .CSRFlagWd(CSRFlagWd),
    .DivReady(DivReady), .PostProcSel(PostProcSel), .PipeGrant(PipeGrant),
    .DivGrant(DivGrant), .SchedStallM(SchedStallM), .ResValid(ResValid),
    .FFlags(FFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; PipeValidM = 0; StallM = 0; FlushM = 0; DivDone = 0;
    DivFlush = 0; CSRFlagWe = 0; CSRFlagWd = 0; PostProcFlg = 0;
  endtask

  // One clock: check combinational outputs mid-cycle against the model,
  // then advance the model at the rising edge.
  task automatic cycle();
    bit pReq, dG, pG, v;
    @(negedge clk);
    pReq = PipeValidM && !StallM && !FlushM;
    dG   = mPend && !DivFlush && (!pReq || mLoss >= MAXWAIT);
    pG   = pReq && !dG;
    v    = pG || dG;
    chk("DivReady",    8'(DivReady),    8'(!mPend));
    chk("DivGrant",    8'(DivGrant),    8'(dG));
    chk("PipeGrant",   8'(PipeGrant),   8'(pG));
    chk("SchedStallM", 8'(SchedStallM), 8'(pReq && dG));
    chk("PostProcSel", 8'(PostProcSel), 8'(dG));
    chk("ResValid",    8'(ResValid),    8'(v));
    chk("FFlags",      8'(FFlags),      8'(mFlags));
    obsDivG = DivGrant;
    @(posedge clk);
    if (reset) begin
      mPend = 0; mLoss = 0; mFlags = '0;
    end else begin
      if (CSRFlagWe) mFlags = CSRFlagWd | (v ? PostProcFlg : 5'd0);
      else if (v)    mFlags = mFlags | PostProcFlg;
      if (DivFlush) begin
        mPend = 0; mLoss = 0;
      end else if (mPend) begin
        if (dG) begin mPend = 0; mLoss = 0; end
        else mLoss++;
      end else if (DivDone) begin
        mPend = 1; mLoss = 0;
      end
    end
    #1;
  endtask

  task automatic doReset();
    idle(); reset = 1;
    cycle(); cycle();
    reset = 0;
  endtask

  initial begin
    int idx, cnt;
    mPend = 0; mLoss = 0; mFlags = 'x;
    idle(); reset = 1;
    @(posedge clk); #1;
    mPend = 0; mLoss = 0; mFlags = '0;
    cycle();
    reset = 0;
    // Reset state
    chk("rst_ready", 8'(DivReady), 8'd1);
    chk("rst_flags", 8'(FFlags), 8'd0);

    // 1: pipe-only traffic
    PipeValidM = 1; PostProcFlg = 5'b00001;
    repeat (4) cycle();
    chk("t1_flags", 8'(FFlags), 8'h01);
    idle(); doReset();

    // 2: single div result with no pipe traffic
    DivDone = 1; PostProcFlg = 5'b01000;
    cycle();
    DivDone = 0;
    chk("t2_notready", 8'(DivReady), 8'd0);
    cycle();
    chk("t2_flags", 8'(FFlags), 8'h08);
    chk("t2_ready", 8'(DivReady), 8'd1);
    idle(); doReset();

    // 3: starvation bound under continuous pipe requests
    DivDone = 1; cycle(); DivDone = 0;
    PipeValidM = 1; idx = -1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (obsDivG && idx < 0) idx = k;
    end
    chk("t3_wait", 8'(idx), 8'(MAXWAIT));
    idle(); doReset();

    // 4: DivDone while HELD is ignored
    PipeValidM = 1; cnt = 0;
    DivDone = 1;
    for (int k = 0; k < 3; k++) begin cycle(); cnt += int'(obsDivG); end
    DivDone = 0;
    for (int k = 0; k < 6; k++) begin cycle(); cnt += int'(obsDivG); end
    chk("t4_one_grant", 8'(cnt), 8'd1);
    idle(); doReset();

    // 5: CSR write merged with a same-cycle grant, then a plain clear
    PipeValidM = 1; PostProcFlg = 5'b00100; CSRFlagWe = 1; CSRFlagWd = 5'b10000;
    cycle();
    chk("t5_merge", 8'(FFlags), 8'h14);
    idle(); CSRFlagWe = 1; PostProcFlg = 5'b11111;
    cycle();
    chk("t5_clear", 8'(FFlags), 8'h00);
    idle(); doReset();

    // 6: flush of a pending result, and flush coincident with done
    PipeValidM = 1; PostProcFlg = 5'b00010; cycle();
    DivDone = 1; PipeValidM = 0; PostProcFlg = 5'b01000; cycle();
    DivDone = 0; DivFlush = 1; cycle();
    chk("t6_flags", 8'(FFlags), 8'h02);
    chk("t6_ready", 8'(DivReady), 8'd1);
    DivDone = 1; DivFlush = 1; cycle();
    DivDone = 0; DivFlush = 0;
    chk("t6_nocapture", 8'(DivReady), 8'd1);
    cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset       = ($urandom_range(63) == 0);
      PipeValidM  = ($urandom_range(3) != 0);
      StallM      = ($urandom_range(7) == 0);
      FlushM      = ($urandom_range(7) == 0);
      DivDone     = ($urandom_range(3) == 0);
      DivFlush    = ($urandom_range(15) == 0);
      CSRFlagWe   = ($urandom_range(9) == 0);
      CSRFlagWd   = 5'($urandom);
      PostProcFlg = 5'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
